// File: rtl/button_led_pio.sv
// Avalon-MM button/LED PIO: debounced buttons with edge capture and a maskable
// level interrupt, plus LED outputs with per-bit hardware blinking.

module button_lane #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int EDGE_MODE         = 0,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic osc_clk,
    input  logic reset,
    input  logic pin,
    output logic state,
    output logic hit
);
    localparam int   CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic IDLE  = (BUTTON_ACTIVE_LOW != 0);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed, update;

    assign pressed = sync2 ^ IDLE;
    assign update  = (pressed != state) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        hit = 1'b0;
        if (update) begin
            case (EDGE_MODE)
                0:       hit = pressed;
                1:       hit = ~pressed;
                default: hit = 1'b1;
            endcase
        end
    end

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (pressed == state || update)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (update)
                state <= pressed;
        end
    end
endmodule

module button_led_pio #(
    parameter int N_BUTTONS         = 4,
    parameter int N_LEDS            = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int EDGE_MODE         = 0,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int LED_ACTIVE_LOW    = 0
) (
    input  logic                 osc_clk,
    input  logic                 reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_LEDS-1:0]    led
);
    localparam logic [N_LEDS-1:0] LED_INV = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_BUTTONS-1:0] state, edge_hit, irq_mask, edge_cap;
    logic [N_LEDS-1:0]    led_out, led_blink, led_on;
    logic [23:0]          blink_div, blink_cnt;
    logic                 blink_phase;
    logic [31:0]          rd_mux;
    logic                 unused_wd;

    logic wr_mask, wr_ecap, wr_lout, wr_blink, wr_div;
    assign wr_mask  = avs_write && (avs_address == 3'd1);
    assign wr_ecap  = avs_write && (avs_address == 3'd2);
    assign wr_lout  = avs_write && (avs_address == 3'd3);
    assign wr_blink = avs_write && (avs_address == 3'd4);
    assign wr_div   = avs_write && (avs_address == 3'd5);
    assign unused_wd = ^avs_writedata;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        button_lane #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .EDGE_MODE        (EDGE_MODE),
            .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
        ) u_lane (
            .osc_clk(osc_clk),
            .reset  (reset),
            .pin    (button[i]),
            .state  (state[i]),
            .hit    (edge_hit[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0: rd_mux[N_BUTTONS-1:0] = state;
            3'd1: rd_mux[N_BUTTONS-1:0] = irq_mask;
            3'd2: rd_mux[N_BUTTONS-1:0] = edge_cap;
            3'd3: rd_mux[N_LEDS-1:0]    = led_out;
            3'd4: rd_mux[N_LEDS-1:0]    = led_blink;
            3'd5: rd_mux[23:0]          = blink_div;
            default: rd_mux = '0;
        endcase
    end

    assign led_on = led_out & ~(led_blink & {N_LEDS{blink_phase}});

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            led_out      <= '0;
            led_blink    <= '0;
            blink_div    <= 24'hFFFFFF;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            irq          <= 1'b0;
            avs_readdata <= '0;
            led          <= LED_INV;
        end else begin
            if (avs_read)
                avs_readdata <= rd_mux;
            if (wr_mask)  irq_mask  <= avs_writedata[N_BUTTONS-1:0];
            if (wr_lout)  led_out   <= avs_writedata[N_LEDS-1:0];
            if (wr_blink) led_blink <= avs_writedata[N_LEDS-1:0];
            // New captures are OR-ed in after the clear so a same-cycle set wins.
            edge_cap <= (edge_cap & ~(wr_ecap ? avs_writedata[N_BUTTONS-1:0] : '0)) | edge_hit;
            irq      <= |(edge_cap & irq_mask);
            if (wr_div) begin
                blink_div   <= avs_writedata[23:0];
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == blink_div) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
            led <= led_on ^ LED_INV;
        end
    end
endmodule

// File: tb/tb_button_led_pio.sv
// Directed bench for button_led_pio: a press-edge instance and a both-edge
// instance share one bus; expected values are hand-derived cycle counts.

module tb_button_led_pio;
    logic        osc_clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] rdata, rdata2;
    logic        irq, irq2;
    logic [3:0]  btn, btn2, led, led2;

    int n_chk = 0;
    int n_err = 0;

    always #5 osc_clk = ~osc_clk;

    button_led_pio #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_dut (
        .osc_clk(osc_clk), .reset(reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata), .irq(irq), .button(btn), .led(led)
    );

    button_led_pio #(.DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_dut2 (
        .osc_clk(osc_clk), .reset(reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata2), .irq(irq2), .button(btn2), .led(led2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each bus task is called at a negedge, issues on the next posedge and
    // returns at the following negedge with readdata valid.
    task automatic bus_rd(input logic [2:0] a);
        avs_address = a; avs_read = 1'b1;
        @(negedge osc_clk);
        avs_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge osc_clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_rw(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b1;
        @(negedge osc_clk);
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic chk_reset_regs(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a));
            chk($sformatf("%s_addr%0d", tag, a), rdata, (a == 5) ? 32'h00FFFFFF : 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; btn = '1; btn2 = '1;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        idle(3);
        reset = 1'b0;

        // Reset values
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk_reset_regs("rst");

        // Glitch shorter than the debounce window is dropped
        bus_wr(3'd1, 32'h1);
        btn[0] = 1'b0; idle(3); btn[0] = 1'b1; idle(10);
        bus_rd(3'd0); chk("glitch_state", rdata, 32'h0);
        bus_rd(3'd2); chk("glitch_ecap", rdata, 32'h0);

        // Held press: STATE/EDGE_CAP at k+5, irq at k+6
        btn[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_rd(3'd0);
            chk($sformatf("press_state_%0d", i), rdata, 32'(i >= 6));
            chk($sformatf("press_irq_%0d", i), 32'(irq), 32'(i >= 6));
        end
        bus_rd(3'd2); chk("press_ecap", rdata, 32'h1);

        // readdata holds without a read; read+write returns the pre-write value
        idle(2); chk("rd_hold", rdata, 32'h1);
        bus_rw(3'd1, 32'h3); chk("rw_old", rdata, 32'h1);
        bus_rd(3'd1);        chk("rw_new", rdata, 32'h3);
        bus_wr(3'd1, 32'h1);

        // W1C racing a new press capture: set wins
        btn[0] = 1'b1; idle(10);
        bus_rd(3'd0); chk("rel_state", rdata, 32'h0);
        btn[0] = 1'b0; idle(5);
        bus_wr(3'd2, 32'h1);
        bus_rd(3'd2); chk("race_ecap", rdata, 32'h1);
        chk("race_irq", 32'(irq), 32'h1);
        bus_wr(3'd2, 32'h1);
        chk("w1c_irq_lag", 32'(irq), 32'h1);
        idle(1);
        chk("w1c_irq_low", 32'(irq), 32'h0);
        bus_rd(3'd2); chk("w1c_ecap", rdata, 32'h0);
        btn[0] = 1'b1; idle(10);
        bus_rd(3'd2); chk("rel_no_edge", rdata, 32'h0);

        // Both-edge mode on the second instance
        bus_wr(3'd1, 32'hF);
        btn2[2] = 1'b0; idle(10);
        bus_rd(3'd2); chk("both_press_ecap", rdata2, 32'h4);
        bus_rd(3'd0); chk("both_press_state", rdata2, 32'h4);
        chk("both_irq", 32'(irq2), 32'h1);
        bus_wr(3'd2, 32'h4);
        bus_rd(3'd2); chk("both_clr", rdata2, 32'h0);
        btn2[2] = 1'b1; idle(10);
        bus_rd(3'd2); chk("both_rel_ecap", rdata2, 32'h4);
        bus_rd(3'd0); chk("both_rel_state", rdata2, 32'h0);

        // Blink: bits 0 and 2 off for 4 cycles out of 8
        bus_wr(3'd3, 32'hF);
        bus_wr(3'd4, 32'h5);
        bus_wr(3'd5, 32'h3);
        for (int j = 1; j <= 17; j++) begin
            idle(1);
            chk($sformatf("blink_%0d", j), 32'(led),
                (((j - 1) / 4) % 2 == 1) ? 32'hA : 32'hF);
        end
        bus_rd(3'd5); chk("blink_div", rdata, 32'h3);

        // Reset mid-debounce and mid-blink
        btn[1] = 1'b0; idle(2);
        reset = 1'b1; btn[1] = 1'b1; idle(2);
        reset = 1'b0;
        chk("mid_led", 32'(led), 32'h0);
        chk("mid_irq", 32'(irq), 32'h0);
        chk("mid_irq2", 32'(irq2), 32'h0);
        chk_reset_regs("mid");
        idle(10);
        bus_rd(3'd2); chk("mid_ecap", rdata, 32'h0);
        bus_rd(3'd0); chk("mid_state", rdata, 32'h0);
        chk("mid_led_late", 32'(led), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
